// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad-driven operand/operator sequencer with ALU start/done handshake
module calc_sequencer #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        alu_done,
    input  logic [13:0] alu_result,
    input  logic        alu_neg,
    output logic [6:0]  op_a,
    output logic [6:0]  op_b,
    output logic [1:0]  op_sel,
    output logic        alu_start,
    output logic [13:0] result,
    output logic        result_neg,
    output logic        result_valid,
    output logic        entry_b,
    output logic        busy,
    output logic        error
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_SHOW    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [6:0]    a_q, a_n, b_q, b_n;
    logic [1:0]    ca_q, ca_n, cb_q, cb_n;
    logic [1:0]    sel_q, sel_n;
    logic [13:0]   res_q, res_n;
    logic          neg_q, neg_n;
    logic [TW-1:0] tmr_q, tmr_n;

    logic       is_digit, is_op, is_clear, is_eq, do_clear;
    logic [1:0] key_op;

    assign is_digit = key_valid && (key_code < 4'd10);
    assign is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
    assign is_clear = key_valid && (key_code == 4'd13);
    assign is_eq    = key_valid && (key_code == 4'd14);
    // Codes 10/11/12 map to 00/01/10 by subtracting 2 from the low bits.
    assign key_op   = key_code[1:0] - 2'd2;

    // Callers only shift in while the count is below 2, so v is at most 9 here.
    function automatic logic [6:0] shift_in(input logic [6:0] v, input logic [3:0] d);
        return 7'(v * 7'd10) + {3'b000, d};
    endfunction

    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        ca_n     = ca_q;
        cb_n     = cb_q;
        sel_n    = sel_q;
        res_n    = res_q;
        neg_n    = neg_q;
        tmr_n    = tmr_q;
        do_clear = 1'b0;
        unique case (state)
            S_ENTER_A: begin
                if (is_digit) begin
                    if (ca_q < 2'd2) begin
                        a_n  = shift_in(a_q, key_code);
                        ca_n = ca_q + 2'd1;
                    end
                end else if (is_op) begin
                    sel_n   = key_op;
                    b_n     = '0;
                    cb_n    = '0;
                    state_n = S_ENTER_B;
                end else if (is_clear) begin
                    a_n  = '0;
                    ca_n = '0;
                end
            end
            S_ENTER_B: begin
                if (is_digit) begin
                    if (cb_q < 2'd2) begin
                        b_n  = shift_in(b_q, key_code);
                        cb_n = cb_q + 2'd1;
                    end
                end else if (is_op) begin
                    sel_n = key_op;
                end else if (is_eq) begin
                    state_n = S_ISSUE;
                end else if (is_clear) begin
                    do_clear = 1'b1;
                end
            end
            S_ISSUE: begin
                tmr_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // Clear beats a coincident done; the result is then discarded.
                if (is_clear) begin
                    do_clear = 1'b1;
                end else if (alu_done) begin
                    res_n   = alu_result;
                    neg_n   = alu_neg;
                    state_n = S_SHOW;
                end else if (tmr_q == TMR_LAST) begin
                    state_n = S_ERR;
                end else begin
                    tmr_n = tmr_q + 1'b1;
                end
            end
            S_SHOW: begin
                if (is_digit) begin
                    a_n     = {3'b000, key_code};
                    ca_n    = 2'd1;
                    b_n     = '0;
                    cb_n    = '0;
                    state_n = S_ENTER_A;
                end else if (is_op) begin
                    // Only a non-negative two-digit result can become operand A.
                    if (!neg_q && (res_q <= 14'd99)) begin
                        a_n     = res_q[6:0];
                        ca_n    = 2'd2;
                        sel_n   = key_op;
                        b_n     = '0;
                        cb_n    = '0;
                        state_n = S_ENTER_B;
                    end
                end else if (is_clear) begin
                    do_clear = 1'b1;
                end
            end
            S_ERR: begin
                if (is_clear) begin
                    do_clear = 1'b1;
                end
            end
            default: state_n = S_ENTER_A;
        endcase
        if (do_clear) begin
            a_n     = '0;
            b_n     = '0;
            ca_n    = '0;
            cb_n    = '0;
            sel_n   = '0;
            res_n   = '0;
            neg_n   = 1'b0;
            state_n = S_ENTER_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ENTER_A;
            a_q   <= '0;
            b_q   <= '0;
            ca_q  <= '0;
            cb_q  <= '0;
            sel_q <= '0;
            res_q <= '0;
            neg_q <= 1'b0;
            tmr_q <= '0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            ca_q  <= ca_n;
            cb_q  <= cb_n;
            sel_q <= sel_n;
            res_q <= res_n;
            neg_q <= neg_n;
            tmr_q <= tmr_n;
        end
    end

    // Status outputs decode the state register only, so no input reaches an output combinationally.
    assign op_a         = a_q;
    assign op_b         = b_q;
    assign op_sel       = sel_q;
    assign result       = res_q;
    assign result_neg   = neg_q;
    assign alu_start    = (state == S_ISSUE);
    assign result_valid = (state == S_SHOW);
    assign entry_b      = (state == S_ENTER_B);
    assign busy         = (state == S_ISSUE) || (state == S_WAIT);
    assign error        = (state == S_ERR);

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keypad-driven sequencer for the calculator datapath. It consumes debounced key codes from the keypad scanner and assembles two 2-digit decimal operands and an operator. It then issues a start/done handshake to the multi-cycle arithmetic unit and holds the signed result for the 7-segment display logic. It also supports chaining a result into the next operation and aborts via timeout or clear.

## Interface
- TIMEOUT, 1024, cycles in WAIT without `alu_done` before entering ERR; minimum 2; timer width is clog2(TIMEOUT).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle pulse per debounced key press.
- key_code  in  4  key meanings:
  - 0–9: digit
  - 10: add
  - 11: subtract
  - 12: multiply
  - 13: clear
  - 14: equals
  - 15: ignored
- alu_done  in  1  one-cycle pulse; the arithmetic unit has finished.
- alu_result  in  14  result magnitude, 0–9801.
- alu_neg  in  1  result sign; 1 = negative.
- op_a  out  7  operand A, 0–99.
- op_b  out  7  operand B, 0–99.
- op_sel  out  2  operator: 00 add, 01 sub, 10 mul.
- alu_start  out  1  one-cycle start pulse.
- result  out  14  captured magnitude.
- result_neg  out  1  captured sign.
- result_valid  out  1  high in SHOW.
- entry_b  out  1  high in ENTER_B; display select.
- busy  out  1  high in ISSUE or WAIT.
- error  out  1  high in ERR.

## Operation
- Reset: state ENTER_A; every output 0; digit counters 0.
- A key is sampled on the rising edge where key_valid=1. Digit entry: operand ← operand*10 + d while its count < 2. Later digits are ignored.
- ENTER_A:
  - digit → enter into A.
  - operator → latch op_sel, clear B and its count, go to ENTER_B.
  - 14 → ignored.
  - 13 → A=0, count=0.
- ENTER_B:
  - digit → enter into B.
  - operator → overwrite op_sel; B unchanged.
  - 14 → ISSUE.
  - 13 → full clear to ENTER_A.
- ISSUE: alu_start=1 for exactly this cycle; timer=0; go to WAIT unconditionally. All keys ignored.
- WAIT:
  - alu_done → capture result and result_neg, go to SHOW.
  - Otherwise, if the timer reaches TIMEOUT-1, go to ERR; else timer+1.
  - Key 13 aborts to ENTER_A with a full clear.
  - Key 13 together with alu_done: clear wins, and the result is not captured.
  - Other keys are ignored.
- SHOW (result_valid=1):
  - digit → A=digit, count=1, B=0, result_valid drops, go to ENTER_A.
  - operator → chains only if result_neg=0 and result ≤ 99: A=result, A count=2, latch op_sel, B=0, go to ENTER_B. Otherwise the key is ignored.
  - 14 → ignored.
  - 13 → full clear.
- ERR: error=1; op_a, op_b and result hold. Only key 13 exits, performing a full clear to ENTER_A.
- Full clear: A, B, counts, op_sel, result and result_neg all set to 0.
- op_a, op_b and op_sel are stable from ISSUE until leaving WAIT.

## Timing
- All outputs are registered; no combinational paths from inputs to outputs.
- Key at edge N updates operands and state after edge N. Equals sampled at edge N gives alu_start high in cycle N+1 and busy high in cycles N+1 onward.
- alu_done sampled at edge M gives result_valid=1 and result updated from cycle M+1; busy=0 from the same cycle.
- alu_done outside WAIT is ignored. alu_done in the ISSUE cycle is also ignored; the ALU must respond no earlier than the cycle after alu_start.
- Timeout: with no alu_done, error=1 exactly TIMEOUT cycles after entering WAIT.
- Asynchronous rst forces reset values immediately, mid-operation included. An alu_done arriving after reset is ignored.

## Test plan
- Basic add: reset; keys 4,2,10,1,7,14; ALU model asserts done 3 cycles after start with 59/pos. Required:
  - op_a=42, op_b=17, op_sel=00.
  - alu_start is a single-cycle pulse.
  - result=59, result_neg=0, result_valid=1, busy=0.
- Digit saturation: keys 1,2,3 → op_a=12. Then 10,9,8,7 → op_b=98, entry_b=1.
- Negative result: keys 5,11,9,14; ALU returns 4/neg → result=4, result_neg=1. Key 10 is then ignored (still SHOW, op_a=5).
- Chaining: keys 3,0,12,2,14; ALU returns 60 → then keys 12,9,14 give op_a=60, op_b=9, op_sel=10, and a second alu_start.
- Timeout: TIMEOUT=16; keys 1,10,1,14; no alu_done.
  - error=1 and busy=0 exactly 16 cycles after entering WAIT.
  - Keys 5 and 14 are ignored.
  - Key 13 → error=0, op_a=0, entry_b=0.
- Reset and clear races:
  - rst pulsed mid-WAIT → all outputs 0 immediately; a later alu_done leaves result_valid=0.
  - Key 13 coincident with alu_done → ENTER_A, result=0.
